// File: rtl/vec_dispatch_queue_pkg.sv
// Shared constants, state type and decode helper for the vector dispatch queue.
package vec_dispatch_queue_pkg;

    localparam logic [6:0] OPCODE_OPV   = 7'b1010111;
    localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
    localparam logic [2:0] FUNCT3_OPMVX = 3'b110;
    localparam logic [2:0] FUNCT3_OPIVV = 3'b000;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } vdq_state_e;

    // Vector-scalar forms (OPIVX / OPMVX) read rs1 from the scalar regfile.
    function automatic logic needs_scalar(input logic [2:0] funct3);
        return (funct3 == FUNCT3_OPIVX) || (funct3 == FUNCT3_OPMVX);
    endfunction

endpackage

// File: rtl/vdq_fifo.sv
// Synchronous FIFO for queued {instr, scalar} entries.
// Ports: clk, nrst (async active-low), flush (sync clear), push/wdata,
//        pop/rdata (head, combinational), full, empty, count.
// Entry storage is not reset; only pointers and count are.
module vdq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Plain register array, no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vec_dispatch_queue.sv
// Dispatch bridge from the scalar core to the vector coprocessor.
// Filters OP-V instructions, captures rs1 for vector-scalar forms, queues
// them (DEPTH entries + one output register) and presents them with a
// valid/ready handshake.
// Ports: clk, nrst; core side instr_valid/instr/instr_ready, scalar regfile
//        read xreg_addr/xreg_data; flush; coprocessor side v_valid/v_instr/
//        v_scalar/v_ready; status occupancy and dispatch_cnt.
module vec_dispatch_queue
    import vec_dispatch_queue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned REGFILE_BITS   = 5,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned CAPTURE_SCALAR = 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      instr_valid,
    input  logic [WORD_WIDTH-1:0]     instr,
    output logic                      instr_ready,
    output logic [REGFILE_BITS-1:0]   xreg_addr,
    input  logic [WORD_WIDTH-1:0]     xreg_data,
    input  logic                      flush,
    output logic                      v_valid,
    output logic [WORD_WIDTH-1:0]     v_instr,
    output logic [WORD_WIDTH-1:0]     v_scalar,
    input  logic                      v_ready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               dispatch_cnt
);

    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = 2 * WORD_WIDTH;

    vdq_state_e            state_q;
    vdq_state_e            state_d;
    logic                  is_opv;
    logic                  push;
    logic                  xfer;
    logic                  out_free;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OCC_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  load_head;
    logic                  load_direct;
    logic [WORD_WIDTH-1:0] scalar_c;

    // OP-V filter and acceptance; non-OP-V never pushes.
    assign is_opv      = (instr[6:0] == OPCODE_OPV);
    assign instr_ready = (occupancy < OCC_W'(DEPTH + 1)) && !flush;
    assign push        = instr_valid && is_opv && instr_ready;

    // Scalar operand capture.
    generate
        if (CAPTURE_SCALAR != 0) begin : g_capture
            assign xreg_addr = instr[15 +: REGFILE_BITS];
            assign scalar_c  = needs_scalar(instr[14:12]) ? xreg_data : '0;
        end else begin : g_no_capture
            assign xreg_addr = '0;
            assign scalar_c  = '0;
        end
    endgenerate

    vdq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({instr, scalar_c}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign v_valid   = (state_q == PRESENT);
    assign xfer      = v_valid && v_ready;
    assign out_free  = !v_valid || v_ready;
    assign occupancy = fifo_count + OCC_W'(v_valid);

    // Output register refill: queue head first; a push into an empty queue
    // goes straight into the output register (registered, one-cycle latency).
    always_comb begin
        state_d     = state_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        load_head   = 1'b0;
        load_direct = 1'b0;
        if (out_free) begin
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                load_head = 1'b1;
                fifo_push = push;
            end else if (push) begin
                load_direct = 1'b1;
            end
        end else begin
            fifo_push = push && !fifo_full;
        end
        case (state_q)
            IDLE:    if (load_head || load_direct) state_d = PRESENT;
            PRESENT: if (xfer && !(load_head || load_direct)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output registers and transfer counter; a transfer in a flush cycle counts.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_instr      <= '0;
            v_scalar     <= '0;
            dispatch_cnt <= '0;
        end else begin
            if (load_head) begin
                {v_instr, v_scalar} <= fifo_rdata;
            end else if (load_direct) begin
                v_instr  <= instr;
                v_scalar <= scalar_c;
            end
            dispatch_cnt <= dispatch_cnt + 32'(xfer);
        end
    end

endmodule
